// File: rtl/rfft_pkg.sv
// Shared constants and types for the 4-lane 256-point radix-2 FFT datapath.
// No ports; imported by rfft_bfly and rfft_4pt256.
package rfft_pkg;

    localparam int unsigned DATA_BIT   = 16;  // real/imag component width
    localparam int unsigned ADDR_BIT   = 6;   // per-bank address width
    localparam int unsigned MEM_HEIGHT = 64;  // words per bank
    localparam int unsigned TW_FRAC    = 14;  // twiddle fraction bits, Q2.14
    localparam int unsigned NUM_BANKS  = 4;

    typedef struct packed {
        logic signed [DATA_BIT-1:0] re;
        logic signed [DATA_BIT-1:0] im;
    } cplx_t;

endpackage

// File: rtl/rfft_bfly.sv
// One complex radix-2 butterfly with twiddle multiply and bypass.
//   xa_i, xb_i : butterfly inputs
//   w_i        : twiddle, Q2.14 signed
//   bypass_i   : 1 = skip the multiply (t = xb)
//   ya_o       : xa + t
//   yb_o       : xa - t
// Purely combinational; all sums wrap modulo 2^DATA_BIT.
module rfft_bfly
    import rfft_pkg::*;
(
    input  cplx_t xa_i,
    input  cplx_t xb_i,
    input  cplx_t w_i,
    input  logic  bypass_i,
    output cplx_t ya_o,
    output cplx_t yb_o
);

    logic signed [2*DATA_BIT-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*DATA_BIT-1:0] acc_re, acc_im;
    cplx_t t;

    always_comb begin
        p_rr   = (2*DATA_BIT)'(xb_i.re) * (2*DATA_BIT)'(w_i.re);
        p_ii   = (2*DATA_BIT)'(xb_i.im) * (2*DATA_BIT)'(w_i.im);
        p_ri   = (2*DATA_BIT)'(xb_i.re) * (2*DATA_BIT)'(w_i.im);
        p_ir   = (2*DATA_BIT)'(xb_i.im) * (2*DATA_BIT)'(w_i.re);
        acc_re = p_rr - p_ii;
        acc_im = p_ri + p_ir;
        // Arithmetic shift then keep the low DATA_BIT bits (truncation, no rounding).
        if (bypass_i) begin
            t = xb_i;
        end else begin
            t.re = DATA_BIT'(acc_re >>> TW_FRAC);
            t.im = DATA_BIT'(acc_im >>> TW_FRAC);
        end
        ya_o.re = xa_i.re + t.re;
        ya_o.im = xa_i.im + t.im;
        yb_o.re = xa_i.re - t.re;
        yb_o.im = xa_i.im - t.im;
    end

endmodule

// File: rtl/rfft_4pt256.sv
// Four-lane in-place radix-2 FFT datapath (256 points, four 64-word banks).
//   clk, rst            : clock, synchronous active-high reset
//   in0_i..in3_i        : real load data for banks 0..3 (imag loaded as 0)
//   mem0_o..mem3_o      : registered read data, real part
//   mem0_i_o..mem3_i_o  : registered read data, imag part
//   m0_i                : write source, 0 = load data, 1 = butterfly results
//   m11_i..m14_i        : input crossbar selects for x0..x3
//   m21_i..m24_i        : output crossbar selects for banks 0..3
//   en_i                : global enable, 0 freezes all state
//   we_i, re_i          : write / read enable
//   w_r_i, w_i_i        : twiddle, Q2.14 signed
//   bypass_en_i         : 1 = twiddle multiply bypassed
//   addr_read_i         : bank K read address in bits [6K+5:6K]
//   addr_write_i        : bank K write address in bits [6K+5:6K]
// A compute read captures its control alongside the read data so the
// butterfly results are written exactly one enabled edge later.
module rfft_4pt256
    import rfft_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BIT-1:0]           in0_i,
    input  logic [DATA_BIT-1:0]           in1_i,
    input  logic [DATA_BIT-1:0]           in2_i,
    input  logic [DATA_BIT-1:0]           in3_i,
    output logic [DATA_BIT-1:0]           mem0_o,
    output logic [DATA_BIT-1:0]           mem1_o,
    output logic [DATA_BIT-1:0]           mem2_o,
    output logic [DATA_BIT-1:0]           mem3_o,
    output logic [DATA_BIT-1:0]           mem0_i_o,
    output logic [DATA_BIT-1:0]           mem1_i_o,
    output logic [DATA_BIT-1:0]           mem2_i_o,
    output logic [DATA_BIT-1:0]           mem3_i_o,
    input  logic                          m0_i,
    input  logic                          m11_i,
    input  logic [1:0]                    m12_i,
    input  logic [1:0]                    m13_i,
    input  logic                          m14_i,
    input  logic                          m21_i,
    input  logic                          m22_i,
    input  logic                          m23_i,
    input  logic                          m24_i,
    input  logic                          en_i,
    input  logic                          we_i,
    input  logic                          re_i,
    input  logic [DATA_BIT-1:0]           w_r_i,
    input  logic [DATA_BIT-1:0]           w_i_i,
    input  logic                          bypass_en_i,
    input  logic [NUM_BANKS*ADDR_BIT-1:0] addr_read_i,
    input  logic [NUM_BANKS*ADDR_BIT-1:0] addr_write_i
);

    cplx_t bank_q [NUM_BANKS][MEM_HEIGHT];
    cplx_t rd_q   [NUM_BANKS];

    // Control captured at the compute read edge.
    logic                          m11_q, m14_q;
    logic [1:0]                    m12_q, m13_q;
    logic [3:0]                    m2_q;
    cplx_t                         w_q;
    logic                          bypass_q;
    logic [NUM_BANKS*ADDR_BIT-1:0] waddr_q;
    logic                          cmp_we_q;

    cplx_t                x0, x1, x2, x3, y0, y1, y2, y3;
    cplx_t                bf_out  [NUM_BANKS];
    cplx_t                wr_data [NUM_BANKS];
    logic [ADDR_BIT-1:0]  wr_addr [NUM_BANKS];
    logic [ADDR_BIT-1:0]  rd_addr [NUM_BANKS];
    logic [DATA_BIT-1:0]  load_re [NUM_BANKS];
    logic                 wr_en, wr_cmp;

    always_ff @(posedge clk) begin
        if (rst) begin
            m11_q    <= 1'b0;
            m12_q    <= 2'd0;
            m13_q    <= 2'd0;
            m14_q    <= 1'b0;
            m2_q     <= 4'd0;
            w_q      <= '0;
            bypass_q <= 1'b0;
            waddr_q  <= '0;
            cmp_we_q <= 1'b0;
        end else if (en_i) begin
            // A pending compute write fires once, on the next enabled edge.
            cmp_we_q <= re_i & m0_i & we_i;
            if (re_i && m0_i) begin
                m11_q    <= m11_i;
                m12_q    <= m12_i;
                m13_q    <= m13_i;
                m14_q    <= m14_i;
                m2_q     <= {m24_i, m23_i, m22_i, m21_i};
                w_q.re   <= w_r_i;
                w_q.im   <= w_i_i;
                bypass_q <= bypass_en_i;
                waddr_q  <= addr_write_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_BANKS; k++) rd_q[k] <= '0;
        end else if (en_i && re_i) begin
            for (int k = 0; k < NUM_BANKS; k++) rd_q[k] <= bank_q[k][rd_addr[k]];
        end
    end

    // Banks have no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < NUM_BANKS; k++) bank_q[k][wr_addr[k]] <= wr_data[k];
        end
    end

    always_comb begin
        x0 = m11_q ? rd_q[1] : rd_q[0];
        x1 = rd_q[m12_q];
        x2 = rd_q[m13_q + 2'd1];
        x3 = m14_q ? rd_q[3] : rd_q[2];
    end

    rfft_bfly u_bfly_lo (
        .xa_i     (x0),
        .xb_i     (x1),
        .w_i      (w_q),
        .bypass_i (bypass_q),
        .ya_o     (y0),
        .yb_o     (y1)
    );

    rfft_bfly u_bfly_hi (
        .xa_i     (x2),
        .xb_i     (x3),
        .w_i      (w_q),
        .bypass_i (bypass_q),
        .ya_o     (y2),
        .yb_o     (y3)
    );

    always_comb begin
        bf_out[0] = m2_q[0] ? y1 : y0;
        bf_out[1] = m2_q[1] ? y0 : y1;
        bf_out[2] = m2_q[2] ? y2 : y3;
        bf_out[3] = m2_q[3] ? y3 : y2;
        load_re[0] = in0_i;
        load_re[1] = in1_i;
        load_re[2] = in2_i;
        load_re[3] = in3_i;

        wr_en  = 1'b0;
        wr_cmp = 1'b0;
        if (!rst && en_i) begin
            if (cmp_we_q) begin
                wr_en  = 1'b1;
                wr_cmp = 1'b1;
            end else if (we_i && !m0_i) begin
                wr_en = 1'b1;
            end
        end

        for (int k = 0; k < NUM_BANKS; k++) begin
            rd_addr[k] = addr_read_i[k*ADDR_BIT +: ADDR_BIT];
            if (wr_cmp) begin
                wr_addr[k] = waddr_q[k*ADDR_BIT +: ADDR_BIT];
                wr_data[k] = bf_out[k];
            end else begin
                wr_addr[k]    = addr_write_i[k*ADDR_BIT +: ADDR_BIT];
                wr_data[k].re = load_re[k];
                wr_data[k].im = '0;
            end
        end
    end

    assign mem0_o   = rd_q[0].re;
    assign mem1_o   = rd_q[1].re;
    assign mem2_o   = rd_q[2].re;
    assign mem3_o   = rd_q[3].re;
    assign mem0_i_o = rd_q[0].im;
    assign mem1_i_o = rd_q[1].im;
    assign mem2_i_o = rd_q[2].im;
    assign mem3_i_o = rd_q[3].im;

endmodule

// File: tb/tb_rfft_4pt256.sv
// Randomized self-checking bench for rfft_4pt256 against a word-level bank model.
module tb_rfft_4pt256;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in0, in1, in2, in3;
    logic [15:0] mem0, mem1, mem2, mem3, mem0_im, mem1_im, mem2_im, mem3_im;
    logic        m0, m11, m14, m21, m22, m23, m24;
    logic [1:0]  m12, m13;
    logic        en, we, re, bypass_en;
    logic [15:0] w_r, w_i;
    logic [23:0] addr_read, addr_write;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl  [4][64];
    logic [31:0] obs  [4];
    logic [31:0] held [4];

    always #5 clk = ~clk;

    assign obs[0] = {mem0, mem0_im};
    assign obs[1] = {mem1, mem1_im};
    assign obs[2] = {mem2, mem2_im};
    assign obs[3] = {mem3, mem3_im};

    rfft_4pt256 dut (
        .clk          (clk),
        .rst          (rst),
        .in0_i        (in0),
        .in1_i        (in1),
        .in2_i        (in2),
        .in3_i        (in3),
        .mem0_o       (mem0),
        .mem1_o       (mem1),
        .mem2_o       (mem2),
        .mem3_o       (mem3),
        .mem0_i_o     (mem0_im),
        .mem1_i_o     (mem1_im),
        .mem2_i_o     (mem2_im),
        .mem3_i_o     (mem3_im),
        .m0_i         (m0),
        .m11_i        (m11),
        .m12_i        (m12),
        .m13_i        (m13),
        .m14_i        (m14),
        .m21_i        (m21),
        .m22_i        (m22),
        .m23_i        (m23),
        .m24_i        (m24),
        .en_i         (en),
        .we_i         (we),
        .re_i         (re),
        .w_r_i        (w_r),
        .w_i_i        (w_i),
        .bypass_en_i  (bypass_en),
        .addr_read_i  (addr_read),
        .addr_write_i (addr_write)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Q2.14 complex multiply with exact integer arithmetic, then truncate.
    function automatic logic [31:0] cmul(input logic [31:0] b, input logic [15:0] wr,
                                         input logic [15:0] wi);
        longint br, bi, cr, ci, pr, pi;
        logic [63:0] ur, ui;
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        cr = longint'($signed(wr));
        ci = longint'($signed(wi));
        pr = (br * cr - bi * ci) >>> 14;
        pi = (br * ci + bi * cr) >>> 14;
        ur = pr;
        ui = pi;
        return {ur[15:0], ui[15:0]};
    endfunction

    function automatic logic [31:0] cadd(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] r, i;
        r = a[31:16] + b[31:16];
        i = a[15:0] + b[15:0];
        return {r, i};
    endfunction

    function automatic logic [31:0] csub(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] r, i;
        r = a[31:16] - b[31:16];
        i = a[15:0] - b[15:0];
        return {r, i};
    endfunction

    task automatic load(input logic [5:0] a, input logic [15:0] d0, input logic [15:0] d1,
                        input logic [15:0] d2, input logic [15:0] d3);
        en = 1'b1; m0 = 1'b0; we = 1'b1; re = 1'b0;
        addr_write = {4{a}};
        in0 = d0; in1 = d1; in2 = d2; in3 = d3;
        tick();
        we = 1'b0;
        mdl[0][a] = {d0, 16'h0};
        mdl[1][a] = {d1, 16'h0};
        mdl[2][a] = {d2, 16'h0};
        mdl[3][a] = {d3, 16'h0};
    endtask

    task automatic read_chk(input string tag, input logic [23:0] ra);
        en = 1'b1; m0 = 1'b0; we = 1'b0; re = 1'b1;
        addr_read = ra;
        tick();
        re = 1'b0;
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("%s.b%0d", tag, k), obs[k], mdl[k][ra[6*k +: 6]]);
    endtask

    // One compute pass: read edge, optional en=0 stall, then the write edge
    // (or a reset on that edge when drop is set).
    task automatic do_op(input logic [23:0] ra, input logic [23:0] wa, input logic s11,
                         input logic [1:0] s12, input logic [1:0] s13, input logic s14,
                         input logic [3:0] s2, input logic [15:0] wr, input logic [15:0] wi,
                         input logic byp, input int stall, input logic drop);
        logic [31:0] r [4];
        logic [31:0] x [4];
        logic [31:0] y [4];
        logic [31:0] o [4];
        logic [31:0] t0, t1;
        for (int k = 0; k < 4; k++) r[k] = mdl[k][ra[6*k +: 6]];
        x[0] = s11 ? r[1] : r[0];
        x[1] = r[int'(s12)];
        x[2] = r[(int'(s13) + 1) % 4];
        x[3] = s14 ? r[3] : r[2];
        t0 = byp ? x[1] : cmul(x[1], wr, wi);
        t1 = byp ? x[3] : cmul(x[3], wr, wi);
        y[0] = cadd(x[0], t0);
        y[1] = csub(x[0], t0);
        y[2] = cadd(x[2], t1);
        y[3] = csub(x[2], t1);
        o[0] = s2[0] ? y[1] : y[0];
        o[1] = s2[1] ? y[0] : y[1];
        o[2] = s2[2] ? y[2] : y[3];
        o[3] = s2[3] ? y[3] : y[2];

        en = 1'b1; m0 = 1'b1; re = 1'b1; we = 1'b1;
        addr_read = ra; addr_write = wa;
        m11 = s11; m12 = s12; m13 = s13; m14 = s14;
        {m24, m23, m22, m21} = s2;
        w_r = wr; w_i = wi; bypass_en = byp;
        tick();
        // Scramble live inputs: the write must use the captured control.
        for (int s = 0; s < stall; s++) begin
            en = 1'b0;
            {m11, m12, m13, m14, m21, m22, m23, m24} = 10'($urandom);
            w_r = 16'($urandom); w_i = 16'($urandom); bypass_en = 1'($urandom);
            addr_write = 24'($urandom); addr_read = 24'($urandom);
            tick();
        end
        en = 1'b1; re = 1'b0; we = 1'b0; m0 = 1'b0;
        m11 = ~s11; m12 = s12 + 2'd1; w_r = ~wr; bypass_en = ~byp;
        addr_write = ~wa;
        if (drop) rst = 1'b1;
        tick();
        rst = 1'b0;
        if (!drop)
            for (int k = 0; k < 4; k++) mdl[k][wa[6*k +: 6]] = o[k];
    endtask

    initial begin
        logic [23:0] ra, wa;
        rst = 1'b1; en = 1'b0; we = 1'b0; re = 1'b0; m0 = 1'b0;
        m11 = 0; m12 = 0; m13 = 0; m14 = 0; m21 = 0; m22 = 0; m23 = 0; m24 = 0;
        w_r = 0; w_i = 0; bypass_en = 0; addr_read = 0; addr_write = 0;
        in0 = 0; in1 = 0; in2 = 0; in3 = 0;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) check_eq($sformatf("reset.b%0d", k), obs[k], 32'h0);
        rst = 1'b0;

        for (int a = 0; a < 64; a++)
            load(6'(a), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));

        // Plain load and read back.
        load(6'd5, 16'd5, 16'd69, 16'd133, 16'd197);
        read_chk("load", {4{6'd5}});
        check_eq("load_b0", obs[0], 32'h0005_0000);
        check_eq("load_b3", obs[3], 32'h00C5_0000);

        // Bypass butterfly, identity crossbars.
        load(6'd0, 16'd10, 16'd3, 16'd0, 16'd0);
        do_op({4{6'd0}}, {4{6'd0}}, 1'b0, 2'd1, 2'd1, 1'b1, 4'b1100, 16'h0, 16'h0, 1'b1, 0, 1'b0);
        read_chk("byp", {4{6'd0}});
        check_eq("byp_b0", obs[0], 32'h000D_0000);
        check_eq("byp_b1", obs[1], 32'h0007_0000);

        // Twiddle j.
        load(6'd1, 16'd10, 16'd3, 16'd0, 16'd0);
        do_op({4{6'd1}}, {4{6'd1}}, 1'b0, 2'd1, 2'd1, 1'b1, 4'b1100, 16'h0, 16'h4000, 1'b0, 0,
              1'b0);
        read_chk("twj", {4{6'd1}});
        check_eq("twj_b0", obs[0], 32'h000A_0003);
        check_eq("twj_b1", obs[1], 32'h000A_FFFD);

        // Twiddle 1.0 behaves like bypass.
        load(6'd1, 16'd10, 16'd3, 16'd0, 16'd0);
        do_op({4{6'd1}}, {4{6'd1}}, 1'b0, 2'd1, 2'd1, 1'b1, 4'b1100, 16'h4000, 16'h0, 1'b0, 0,
              1'b0);
        read_chk("tw1", {4{6'd1}});
        check_eq("tw1_b0", obs[0], 32'h000D_0000);
        check_eq("tw1_b1", obs[1], 32'h0007_0000);

        // Non-identity crossbars: x=(2,1,8,4), y=(3,1,12,4), banks=(y1,y0,y3,y2).
        load(6'd2, 16'd1, 16'd2, 16'd4, 16'd8);
        do_op({4{6'd2}}, {4{6'd2}}, 1'b1, 2'd0, 2'd2, 1'b0, 4'b0011, 16'h0, 16'h0, 1'b1, 0, 1'b0);
        read_chk("xbar", {4{6'd2}});
        check_eq("xbar_b0", obs[0], 32'h0001_0000);
        check_eq("xbar_b1", obs[1], 32'h0003_0000);
        check_eq("xbar_b2", obs[2], 32'h0004_0000);
        check_eq("xbar_b3", obs[3], 32'h000C_0000);

        // Same-address load and read: read returns old data.
        en = 1'b1; m0 = 1'b0; we = 1'b1; re = 1'b1;
        addr_read = {4{6'd7}}; addr_write = {4{6'd7}};
        in0 = 16'($urandom); in1 = 16'($urandom); in2 = 16'($urandom); in3 = 16'($urandom);
        tick();
        we = 1'b0; re = 1'b0;
        for (int k = 0; k < 4; k++) check_eq($sformatf("rw_old.b%0d", k), obs[k], mdl[k][7]);
        mdl[0][7] = {in0, 16'h0}; mdl[1][7] = {in1, 16'h0};
        mdl[2][7] = {in2, 16'h0}; mdl[3][7] = {in3, 16'h0};
        read_chk("rw_new", {4{6'd7}});

        // en=0 freezes reads and writes.
        read_chk("pre_hold", {4{6'd9}});
        for (int k = 0; k < 4; k++) held[k] = obs[k];
        en = 1'b0; m0 = 1'b0; we = 1'b1; re = 1'b1;
        addr_write = {4{6'd9}}; addr_read = {4{6'd10}};
        in0 = ~in0; in1 = ~in1; in2 = ~in2; in3 = ~in3;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) check_eq($sformatf("hold.b%0d", k), obs[k], held[k]);
        read_chk("hold_mem", {4{6'd9}});

        // Reset on the write edge drops the pending write and clears read data.
        ra = 24'($urandom);
        wa = 24'($urandom);
        do_op(ra, wa, 1'b0, 2'd1, 2'd1, 1'b1, 4'b1100, 16'h0, 16'h0, 1'b1, 0, 1'b1);
        for (int k = 0; k < 4; k++) check_eq($sformatf("rst_clr.b%0d", k), obs[k], 32'h0);
        read_chk("rst_keep", wa);

        // Random compute passes.
        repeat (60) begin
            ra = 24'($urandom);
            wa = 24'($urandom);
            do_op(ra, wa, 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                  4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                  int'($urandom_range(0, 2)), 1'b0);
            read_chk("rnd", wa);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
